sdio_spi: RTL

SPI transfer engine behind the SDIO register window in Z2 space. It decodes CPU word accesses while `SDIO_ACCESS` is high and answers them with its own DTACK. It clocks bytes to and from the SD card in SPI mode 0. It runs entirely on `CLKCPU`, consumes the access qualifier produced by the SDIO address decoder, and its `DTACK_SDIO_n` is ANDed into the CPU DTACK term by the top level.

---
 rtl/sdio_spi.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/sdio_spi.sv
// SDIO register window and SPI mode-0 byte engine for the SD card.
// Single clock domain (CLKCPU); CPU accesses answered with a local DTACK.
`timescale 1ns/1ps
module sdio_spi #(
    parameter logic [7:0] DIV_RESET = 8'hFF
) (
    input  logic        CLKCPU,
    input  logic        RESET_n,
    input  logic        AS_CPU_n,
    input  logic        DS_n,
    input  logic        RW_n,
    input  logic        SDIO_ACCESS,
    input  logic [1:0]  A_REG,
    input  logic [15:0] D_IN,
    output logic [15:0] D_OUT,
    output logic        D_OE,
    output logic        DTACK_SDIO_n,
    output logic        SD_CLK,
    output logic        SD_MOSI,
    input  logic        SD_MISO,
    output logic        SD_CS_n
);

    typedef enum logic {StIdle, StPhase} state_e;

    localparam logic [1:0] RegData = 2'd0;
    localparam logic [1:0] RegCtrl = 2'd1;
    localparam logic [1:0] RegDiv  = 2'd2;

    state_e      r_state, w_state_next;
    logic [7:0]  r_cnt, w_cnt_next;
    logic [3:0]  r_half, w_half_next;
    logic [7:0]  r_shift, w_shift_next;
    logic        r_sbit, w_sbit_next;
    logic        r_sclk, w_sclk_next;
    logic        r_mosi, w_mosi_next;
    logic [7:0]  r_data, w_data_next;
    logic        r_ctrl, w_ctrl_next;
    logic [7:0]  r_div, w_div_next;
    logic [7:0]  r_divc, w_divc_next;
    logic        r_ack, w_ack_next;
    logic        r_rd, w_rd_next;
    logic [1:0]  r_sel, w_sel_next;

    logic        w_busy, w_tick, w_done, w_stall, w_accept, w_wr, w_start;
    logic [15:0] w_rdata;
    logic        w_unused;

    assign w_busy  = (r_state == StPhase);
    assign w_tick  = w_busy && (r_cnt == 8'd0);
    assign w_done  = w_tick && (r_half == 4'd15);
    // The BUSY-falling edge already accepts a stalled access.
    assign w_stall = w_busy && !w_done && (!RW_n || (A_REG == RegData));
    assign w_accept = !AS_CPU_n && !DS_n && SDIO_ACCESS && !r_ack && !w_stall;
    assign w_wr    = w_accept && !RW_n;
    assign w_start = w_wr && (A_REG == RegData);
    assign w_unused = ^D_IN[15:8];

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_half_next  = r_half;
        w_shift_next = r_shift;
        w_sbit_next  = r_sbit;
        w_sclk_next  = r_sclk;
        w_mosi_next  = r_mosi;
        w_data_next  = r_data;
        w_ctrl_next  = r_ctrl;
        w_div_next   = r_div;
        w_divc_next  = r_divc;
        w_ack_next   = r_ack;
        w_rd_next    = r_rd;
        w_sel_next   = r_sel;

        if (AS_CPU_n) begin
            w_ack_next = 1'b0;
            w_rd_next  = 1'b0;
        end else if (w_accept) begin
            w_ack_next = 1'b1;
            w_rd_next  = RW_n;
            w_sel_next = A_REG;
        end
        if (w_wr && (A_REG == RegCtrl)) w_ctrl_next = D_IN[0];
        if (w_wr && (A_REG == RegDiv))  w_div_next  = D_IN[7:0];

        case (r_state)
            StIdle: begin
                if (w_start) w_state_next = StPhase;
            end
            StPhase: begin
                if (w_tick) begin
                    w_cnt_next  = r_divc;
                    w_half_next = r_half + 4'd1;
                    if (!r_half[0]) begin
                        w_sclk_next = 1'b1;
                        w_sbit_next = SD_MISO;
                    end else begin
                        w_sclk_next  = 1'b0;
                        w_shift_next = {r_shift[6:0], r_sbit};
                        w_mosi_next  = r_shift[6];
                    end
                    if (w_done) begin
                        w_mosi_next  = 1'b1;
                        w_data_next  = {r_shift[6:0], r_sbit};
                        w_state_next = StIdle;
                    end
                end else begin
                    w_cnt_next = r_cnt - 8'd1;
                end
            end
            default: w_state_next = StIdle;
        endcase

        if (w_start) begin
            w_state_next = StPhase;
            w_shift_next = D_IN[7:0];
            w_mosi_next  = D_IN[7];
            w_cnt_next   = r_div;
            w_divc_next  = r_div;
            w_half_next  = 4'd0;
            w_sclk_next  = 1'b0;
        end
    end

    always_ff @(posedge CLKCPU or negedge RESET_n) begin
        if (!RESET_n) begin
            r_state <= StIdle;
            r_cnt   <= 8'd0;
            r_half  <= 4'd0;
            r_shift <= 8'hFF;
            r_sbit  <= 1'b1;
            r_sclk  <= 1'b0;
            r_mosi  <= 1'b1;
            r_data  <= 8'hFF;
            r_ctrl  <= 1'b0;
            r_div   <= DIV_RESET;
            r_divc  <= DIV_RESET;
            r_ack   <= 1'b0;
            r_rd    <= 1'b0;
            r_sel   <= 2'd0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            r_half  <= w_half_next;
            r_shift <= w_shift_next;
            r_sbit  <= w_sbit_next;
            r_sclk  <= w_sclk_next;
            r_mosi  <= w_mosi_next;
            r_data  <= w_data_next;
            r_ctrl  <= w_ctrl_next;
            r_div   <= w_div_next;
            r_divc  <= w_divc_next;
            r_ack   <= w_ack_next;
            r_rd    <= w_rd_next;
            r_sel   <= w_sel_next;
        end
    end

    always_comb begin
        w_rdata = 16'h0000;
        case (r_sel)
            2'd0:    w_rdata = {8'h00, r_data};
            2'd1:    w_rdata = {15'd0, r_ctrl};
            2'd2:    w_rdata = {8'h00, r_div};
            default: w_rdata = {15'd0, w_busy};
        endcase
    end

    assign D_OUT        = r_rd ? w_rdata : 16'h0000;
    assign D_OE         = r_rd;
    assign DTACK_SDIO_n = !r_ack;
    assign SD_CLK       = r_sclk;
    assign SD_MOSI      = r_mosi;
    assign SD_CS_n      = !r_ctrl;

endmodule
